cpu_0_ocimem_responder: RTL and testbench

CPU_0_OCIMEM_RESPONDER -- requirements
Module: cpu_0_ocimem_responder

---
 rtl/cpu_0_ocimem_responder_pkg.sv | 38 +++
 rtl/cpu_0_ocimem_ram.sv | 40 ++++
 rtl/cpu_0_ocimem_responder.sv | 156 +++++++++++++++
 tb/tb_cpu_0_ocimem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_0_ocimem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_0_ocimem_responder_pkg
// Description : Shared types and constants for the OCI debug-memory responder.
//               It defines the FSM state enum, the jdo field bit positions,
//               the RAM geometry and a small address-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_0_ocimem_responder_pkg;

    localparam int JDO_W      = 38;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int RAM_DEPTH  = 256;

    // jdo field positions
    localparam int ADDR_MSB   = 25;
    localparam int ADDR_LSB   = 18;
    localparam int GO_BIT     = 17;
    localparam int CLRERR_BIT = 34;
    localparam int RD_BIT     = 35;
    localparam int WDATA_MSB  = 34;
    localparam int WDATA_LSB  = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_READ_CAP  = 2'd3
    } state_e;

    // Word address post-increment; wraps 255 -> 0 naturally at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_0_ocimem_ram.sv
`default_nettype none
// ============================================================================
// Module      : cpu_0_ocimem_ram
// Description : 256 x 32 single-port RAM, synchronous write, registered read
//               with one cycle of latency. Contents are never reset.
// Ports       : clk     - clock
//               i_we    - write enable
//               i_re    - read enable (updates o_rdata on the next edge)
//               i_addr  - word address
//               i_wdata - write data
//               o_rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_0_ocimem_ram
    import cpu_0_ocimem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [RAM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cpu_0_ocimem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_0_ocimem_responder
// Description : JTAG debug-side responder for the CPU on-chip debug memory.
//               Three one-cycle strobes load an address/command, write a data
//               word, or read the next word. A small FSM sequences the RAM
//               access and reports completion/error back to the JTAG side.
// Ports       : clk, reset (sync, active-high)
//               jdo[37:0]                - JTAG data word
//               take_action_ocimem_a     - load address/go, optional read
//               take_action_ocimem_b     - write data word
//               take_no_action_ocimem_a  - read next word
//               debugack                 - CPU halted; access legal when high
//               MonDReg[31:0]            - monitor data register
//               monitor_ready/error/go   - status outputs
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_0_ocimem_responder
    import cpu_0_ocimem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              monitor_go
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_mon_areg;
    logic [DATA_W-1:0] r_mon_dreg;
    logic              r_ready;
    logic              r_error;
    logic              r_go;
    logic              r_illegal;   // launch happened with debugack low
    logic              r_dbg_q;     // debugack delayed, for falling-edge detect

    logic              w_any_strobe;
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                          take_no_action_ocimem_a;

    // RAM strobes are gated by reset so an aborted operation never writes.
    assign w_we = (r_state == ST_WRITE)     && !r_illegal && !reset;
    assign w_re = (r_state == ST_READ_WAIT) && !r_illegal && !reset;

    // jdo bits outside the decoded fields carry nothing for this block.
    assign w_unused = ^{jdo[JDO_W-1:RD_BIT+1], jdo[WDATA_LSB-1:0]};

    cpu_0_ocimem_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_mon_areg),
        .i_wdata (r_mon_dreg),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mon_areg <= '0;
            r_mon_dreg <= '0;
            r_ready    <= 1'b1;
            r_error    <= 1'b0;
            r_go       <= 1'b0;
            r_illegal  <= 1'b0;
            r_dbg_q    <= 1'b0;
        end else begin
            r_dbg_q <= debugack;

            // Losing the debug halt cancels any pending resume request; a
            // same-cycle address strobe below still takes effect.
            if (r_dbg_q && !debugack) begin
                r_go <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (take_action_ocimem_a) begin
                        r_mon_areg <= jdo[ADDR_MSB:ADDR_LSB];
                        r_go       <= jdo[GO_BIT];
                        r_ready    <= 1'b0;
                        if (jdo[CLRERR_BIT]) begin
                            r_error <= 1'b0;
                        end
                        if (jdo[RD_BIT]) begin
                            r_illegal <= !debugack;
                            r_state   <= ST_READ_WAIT;
                        end
                    end else if (take_action_ocimem_b) begin
                        r_mon_dreg <= jdo[WDATA_MSB:WDATA_LSB];
                        r_ready    <= 1'b0;
                        r_illegal  <= !debugack;
                        r_state    <= ST_WRITE;
                    end else if (take_no_action_ocimem_a) begin
                        r_ready    <= 1'b0;
                        r_illegal  <= !debugack;
                        r_state    <= ST_READ_WAIT;
                    end
                end

                ST_WRITE: begin
                    // The RAM write itself happens this cycle via w_we.
                    if (r_illegal) begin
                        r_error <= 1'b1;
                    end else begin
                        r_mon_areg <= addr_next(r_mon_areg);
                    end
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                ST_READ_WAIT: begin
                    r_state <= ST_READ_CAP;
                end

                ST_READ_CAP: begin
                    if (r_illegal) begin
                        r_error <= 1'b1;
                    end else begin
                        r_mon_dreg <= w_rdata;
                        r_mon_areg <= addr_next(r_mon_areg);
                    end
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A strobe arriving while busy is dropped and flagged.
            if ((r_state != ST_IDLE) && w_any_strobe) begin
                r_error <= 1'b1;
            end
        end
    end

    assign MonDReg       = r_mon_dreg;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
    assign monitor_go    = r_go;

endmodule
`default_nettype wire

// File: tb/tb_cpu_0_ocimem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_0_ocimem_responder
// Description : Directed self-checking bench for cpu_0_ocimem_responder.
//               Inputs change 1 time unit after a rising edge; outputs are
//               sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_0_ocimem_responder;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        debugack;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        monitor_go;

    int n_checks = 0;
    int n_errors = 0;

    cpu_0_ocimem_responder dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .debugack                (debugack),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic go,
                                         input logic clr, input logic rd);
        logic [37:0] j;
        j      = '0;
        j[25:18] = addr;
        j[17]  = go;
        j[34]  = clr;
        j[35]  = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] j;
        j       = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic strobe_a(input logic [37:0] j);
        jdo = j; take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [37:0] j);
        jdo = j; take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic strobe_n();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1; jdo = '0; debugack = 1'b1;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;

        // Reset with strobes asserted: strobes must be ignored.
        tick();
        jdo = mk_b(32'hAAAA5555); take_action_ocimem_b = 1'b1; take_no_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0; reset = 1'b0;
        chk("rst_dreg",  MonDReg, 32'h0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'd1);
        chk("rst_error", {31'b0, monitor_error}, 32'd0);
        chk("rst_go",    {31'b0, monitor_go}, 32'd0);
        chk("rst_areg",  {24'b0, dut.r_mon_areg}, 32'h0);
        tick();
        chk("rst_idle_dreg", MonDReg, 32'h0);

        // Write 0xDEADBEEF at 0x10: ready low at N+1, high at N+2.
        strobe_a(mk_a(8'h10, 1'b1, 1'b0, 1'b0));
        chk("a_go",   {31'b0, monitor_go}, 32'd1);
        chk("a_areg", {24'b0, dut.r_mon_areg}, 32'h10);
        strobe_b(mk_b(32'hDEADBEEF));
        chk("wr_ready_n1", {31'b0, monitor_ready}, 32'd0);
        tick();
        chk("wr_ready_n2", {31'b0, monitor_ready}, 32'd1);
        chk("wr_ram10",    dut.u_ram.r_mem[8'h10], 32'hDEADBEEF);
        chk("wr_areg",     {24'b0, dut.r_mon_areg}, 32'h11);
        chk("wr_error",    {31'b0, monitor_error}, 32'd0);

        // Write 0x0BADF00D at 0x11 for the sequential read below.
        strobe_b(mk_b(32'h0BADF00D));
        tick();
        chk("wr2_areg", {24'b0, dut.r_mon_areg}, 32'h12);

        // Read at 0x10: ready low at N+1 and N+2, data at N+3.
        strobe_a(mk_a(8'h10, 1'b0, 1'b0, 1'b1));
        chk("rd_go_cleared", {31'b0, monitor_go}, 32'd0);
        chk("rd_ready_n1",   {31'b0, monitor_ready}, 32'd0);
        tick();
        chk("rd_ready_n2",   {31'b0, monitor_ready}, 32'd0);
        chk("rd_dreg_hold",  MonDReg, 32'h0BADF00D);
        tick();
        chk("rd_ready_n3",   {31'b0, monitor_ready}, 32'd1);
        chk("rd_dreg",       MonDReg, 32'hDEADBEEF);
        chk("rd_areg",       {24'b0, dut.r_mon_areg}, 32'h11);
        strobe_n();
        tick(); tick();
        chk("rdn_dreg", MonDReg, 32'h0BADF00D);
        chk("rdn_areg", {24'b0, dut.r_mon_areg}, 32'h12);

        // Address wrap 0xFF -> 0x00.
        strobe_a(mk_a(8'hFF, 1'b0, 1'b0, 1'b0));
        strobe_b(mk_b(32'h12345678));
        tick();
        strobe_b(mk_b(32'h9ABCDEF0));
        tick();
        chk("wrap_ramff", dut.u_ram.r_mem[8'hFF], 32'h12345678);
        chk("wrap_ram00", dut.u_ram.r_mem[8'h00], 32'h9ABCDEF0);
        chk("wrap_areg",  {24'b0, dut.r_mon_areg}, 32'h01);
        chk("wrap_error", {31'b0, monitor_error}, 32'd0);
        tick(); tick();
        chk("dreg_hold", MonDReg, 32'h9ABCDEF0);

        // Simultaneous a+b in IDLE: a wins, b dropped, no error.
        jdo = mk_a(8'h40, 1'b0, 1'b0, 1'b0);
        jdo[34:3] = 32'h77777777;
        jdo[25:18] = 8'h40; jdo[17] = 1'b0; jdo[35] = 1'b0; jdo[34] = 1'b0;
        take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        tick();
        chk("simul_areg",  {24'b0, dut.r_mon_areg}, 32'h40);
        chk("simul_dreg",  MonDReg, 32'h9ABCDEF0);
        chk("simul_error", {31'b0, monitor_error}, 32'd0);
        chk("simul_ready", {31'b0, monitor_ready}, 32'd0);

        // monitor_go cleared when debugack falls.
        strobe_a(mk_a(8'h50, 1'b1, 1'b0, 1'b0));
        chk("go_set", {31'b0, monitor_go}, 32'd1);
        debugack = 1'b0;
        tick();
        chk("go_fall", {31'b0, monitor_go}, 32'd0);

        // Illegal write with debugack low.
        strobe_a(mk_a(8'h10, 1'b0, 1'b0, 1'b0));
        strobe_b(mk_b(32'hCAFEF00D));
        chk("ill_ready_n1", {31'b0, monitor_ready}, 32'd0);
        tick();
        chk("ill_ready_n2", {31'b0, monitor_ready}, 32'd1);
        chk("ill_error",    {31'b0, monitor_error}, 32'd1);
        chk("ill_ram10",    dut.u_ram.r_mem[8'h10], 32'hDEADBEEF);
        chk("ill_areg",     {24'b0, dut.r_mon_areg}, 32'h10);
        strobe_a(mk_a(8'h10, 1'b0, 1'b1, 1'b0));
        chk("clr_error",    {31'b0, monitor_error}, 32'd0);

        // Illegal read with debugack low: MonDReg untouched.
        strobe_n();
        tick(); tick();
        chk("illrd_ready", {31'b0, monitor_ready}, 32'd1);
        chk("illrd_error", {31'b0, monitor_error}, 32'd1);
        chk("illrd_dreg",  MonDReg, 32'hCAFEF00D);
        strobe_a(mk_a(8'h30, 1'b0, 1'b1, 1'b0));

        // Back-to-back writes: second is dropped, first lands.
        debugack = 1'b1;
        tick();
        jdo = mk_b(32'h11111111); take_action_ocimem_b = 1'b1;
        tick();
        jdo = mk_b(32'h22222222);
        tick();
        take_action_ocimem_b = 1'b0;
        chk("b2b_ready", {31'b0, monitor_ready}, 32'd1);
        chk("b2b_error", {31'b0, monitor_error}, 32'd1);
        chk("b2b_ram30", dut.u_ram.r_mem[8'h30], 32'h11111111);
        chk("b2b_dreg",  MonDReg, 32'h11111111);
        chk("b2b_areg",  {24'b0, dut.r_mon_areg}, 32'h31);

        // Reset during READ_WAIT.
        strobe_a(mk_a(8'h10, 1'b0, 1'b1, 1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rrst_dreg",  MonDReg, 32'h0);
        chk("rrst_ready", {31'b0, monitor_ready}, 32'd1);
        chk("rrst_error", {31'b0, monitor_error}, 32'd0);
        chk("rrst_ram10", dut.u_ram.r_mem[8'h10], 32'hDEADBEEF);
        tick(); tick();
        chk("rrst_settle", MonDReg, 32'h0);

        // Reset during WRITE: RAM[0] must keep its value.
        strobe_b(mk_b(32'h55555555));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("wrst_ram00", dut.u_ram.r_mem[8'h00], 32'h9ABCDEF0);
        chk("wrst_ready", {31'b0, monitor_ready}, 32'd1);
        chk("wrst_areg",  {24'b0, dut.r_mon_areg}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
